// File: rtl/instruction_fetch.sv
// Fetches ROM words at ProgramCounter over req/ack and queues them for decode; PCHold releases the PC per accepted ack.
// Ack in cycle N gives InstrValid in N+1; requests stall while the FIFO is full, and a stuck ROM latches RomErr until reset.
module instruction_fetch #(
  parameter int IW      = 24,
  parameter int AW      = 7,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [AW-1:0] ProgramCounter,
  output logic          PCHold,
  input  logic          Enable,
  output logic          RomReq,
  output logic [AW-1:0] RomAddr,
  input  logic          RomAck,
  input  logic [IW-1:0] RomData,
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  input  logic          InstrReady,
  output logic          RomErr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [IW-1:0] instr_q, instr_d;

  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // An ack is only honoured while a request is actually outstanding.
  assign push            = (state_q == S_FETCH) && RomAck;
  assign pop             = InstrValid && InstrReady;
  assign count_after_pop = count_q - CW'(pop);

  assign InstrValid = (count_q != '0);
  assign Instr      = instr_q;
  assign PCHold     = ~push;
  assign RomAddr    = ProgramCounter;
  assign RomErr     = (state_q == S_ERROR);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    count_d  = count_after_pop + CW'(push);
    if (push) begin
      mem_d[wr_ptr_q] = RomData;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // Keep the output register equal to the next head; with nothing left it holds.
    if (count_after_pop != '0) begin
      instr_d = mem_q[rd_ptr_d];
    end else if (push) begin
      instr_d = RomData;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    RomReq  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Enable && (count_q < CW'(DEPTH))) begin
          state_d = S_FETCH;
          timer_d = '0;
        end
      end
      S_FETCH: begin
        RomReq = 1'b1;
        if (RomAck) begin
          timer_d = '0;
          if (!(Enable && (count_d < CW'(DEPTH)))) begin
            state_d = S_IDLE;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      instr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench: ROM responder queues the word at the next sequential PC per accepted ack;
// a monitor pops and compares whenever the decoder takes an instruction.
module tb_instruction_fetch;

  localparam int IW = 24;
  localparam int AW = 7;
  localparam int DEPTH = 2;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic [AW-1:0] pc;
  logic          PCHold;
  logic          Enable = 1'b0;
  logic          RomReq;
  logic [AW-1:0] RomAddr;
  logic          RomAck = 1'b0;
  logic [IW-1:0] RomData = '0;
  logic [IW-1:0] Instr;
  logic          InstrValid;
  logic          InstrReady = 1'b0;
  logic          RomErr;

  instruction_fetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .Clock(Clock), .nReset(nReset), .ProgramCounter(pc), .PCHold(PCHold),
    .Enable(Enable), .RomReq(RomReq), .RomAddr(RomAddr), .RomAck(RomAck),
    .RomData(RomData), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .RomErr(RomErr)
  );

  always #5 Clock = ~Clock;

  // PC register environment: advances whenever the fetch unit releases it.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) pc <= '0;
    else if (!PCHold) pc <= pc + 1'b1;
  end

  int            errors = 0;
  int            checks = 0;
  logic [IW-1:0] rom [128];
  logic [IW-1:0] exp_q [$];
  logic [AW-1:0] model_pc = '0;
  int            fixed_wait = 0;
  bit            no_ack = 0;
  bit            force_ack = 0;
  int            n_pop = 0;
  logic [IW-1:0] last_pop = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM responder: waits wcnt cycles per request, then acks with rom[RomAddr].
  initial begin
    int  wcnt;
    bit  acc;
    bit  req_s;
    wcnt = 0;
    forever begin
      @(negedge Clock);
      RomAck  = force_ack || (nReset && RomReq && !no_ack && wcnt == 0);
      RomData = rom[RomAddr];
      #2;
      req_s = RomReq;
      acc   = nReset && RomReq && RomAck;
      if (acc) chk("rom_addr", 32'(RomAddr), 32'(model_pc));
      @(posedge Clock);
      if (acc && nReset) begin
        exp_q.push_back(rom[model_pc]);
        model_pc = model_pc + 1'b1;
      end
      if (!req_s || acc) wcnt = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
      else if (wcnt > 0) wcnt--;
    end
  end

  // Monitor: FIFO occupancy and head word against the scoreboard.
  initial begin
    logic [IW-1:0] e;
    forever begin
      @(negedge Clock);
      #3;
      if (nReset) begin
        chk("instr_valid", 32'(InstrValid), 32'(exp_q.size() != 0));
        if (InstrValid && InstrReady && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("instr", 32'(Instr), 32'(e));
          last_pop = e;
          n_pop++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    #1;
    nReset = 1'b0;
    exp_q.delete();
    model_pc = '0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    int cnt;
    int n0;
    logic [AW-1:0] pc_s;
    for (int i = 0; i < 128; i++) rom[i] = IW'($urandom);
    rom[0] = 24'h123456;

    // T1: reset, idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      #1;
      chk("t1_romreq", 32'(RomReq), 0);
      chk("t1_pchold", 32'(PCHold), 1);
      chk("t1_valid", 32'(InstrValid), 0);
      chk("t1_romerr", 32'(RomErr), 0);
      if (c == 0) chk("t1_instr", 32'(Instr), 0);
    end

    // T2: single fetch with two wait cycles
    fixed_wait = 2;
    Enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #1;
      if (c == 2) Enable = 1'b0;
      chk("t2_romreq", 32'(RomReq), 1);
      chk("t2_romaddr", 32'(RomAddr), 0);
      chk("t2_pchold", 32'(PCHold), (c == 2) ? 0 : 1);
    end
    @(negedge Clock);
    #1;
    chk("t2_valid", 32'(InstrValid), 1);
    chk("t2_instr", 32'(Instr), 32'h123456);
    chk("t2_pc", 32'(pc), 1);
    chk("t2_romreq_after", 32'(RomReq), 0);

    // T3: backpressure with zero-wait ROM
    do_reset();
    fixed_wait = 0;
    InstrReady = 1'b0;
    Enable = 1'b1;
    cycles(10);
    #1;
    chk("t3_acks", 32'(model_pc), 2);
    chk("t3_pc", 32'(pc), 2);
    chk("t3_romreq", 32'(RomReq), 0);
    chk("t3_count", 32'(exp_q.size()), 2);
    InstrReady = 1'b1;
    cycles(10);
    #1;
    chk("t3_resumed", 32'(model_pc > 4), 1);

    // T4: push and pop in the same cycle, one word per cycle
    Enable = 1'b0;
    cycles(6);
    Enable = 1'b1;
    n0 = n_pop;
    for (int c = 0; c < 22; c++) begin
      @(negedge Clock);
      #1;
      if (c >= 12) chk("t4_count", 32'(exp_q.size()), 1);
    end
    chk("t4_throughput", 32'((n_pop - n0) >= 20), 1);
    Enable = 1'b0;
    cycles(6);
    #1;
    chk("t4_drained", 32'(exp_q.size()), 0);
    chk("t4_pc", 32'(pc), 32'(model_pc));

    // Random traffic
    fixed_wait = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      Enable = ($urandom_range(0, 9) != 0);
      InstrReady = 1'($urandom_range(0, 1));
    end
    Enable = 1'b0;
    InstrReady = 1'b1;
    cycles(20);
    #1;
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_pc", 32'(pc), 32'(model_pc));
    chk("rnd_romerr", 32'(RomErr), 0);

    // T5: timeout after one buffered word
    do_reset();
    fixed_wait = 0;
    InstrReady = 1'b0;
    Enable = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      #1;
      if (RomReq && RomAck) begin
        no_ack = 1;
        cnt = 1;
        break;
      end
    end
    chk("t5_first_ack", 32'(cnt), 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      #1;
      if (RomErr) break;
      if (RomReq) cnt++;
    end
    chk("t5_fetch_cycles", 32'(cnt), 15);
    chk("t5_romerr", 32'(RomErr), 1);
    chk("t5_romreq", 32'(RomReq), 0);
    pc_s = pc;
    force_ack = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #2;
      chk("t5_late_pchold", 32'(PCHold), 1);
    end
    force_ack = 0;
    chk("t5_pc_frozen", 32'(pc), 32'(pc_s));
    InstrReady = 1'b1;
    cycles(5);
    #1;
    chk("t5_drained", 32'(exp_q.size()), 0);
    chk("t5_hold_instr", 32'(Instr), 32'(last_pop));
    chk("t5_sticky", 32'(RomErr), 1);
    no_ack = 0;

    // T6: asynchronous reset in the middle of a request
    do_reset();
    fixed_wait = 0;
    InstrReady = 1'b0;
    Enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      #1;
      if (RomReq && RomAck) begin
        fixed_wait = 6;
        break;
      end
    end
    cycles(2);
    #1;
    chk("t6_in_fetch", 32'(RomReq), 1);
    nReset = 1'b0;
    exp_q.delete();
    model_pc = '0;
    #1;
    chk("t6_romreq", 32'(RomReq), 0);
    chk("t6_pchold", 32'(PCHold), 1);
    chk("t6_valid", 32'(InstrValid), 0);
    chk("t6_pc", 32'(pc), 0);
    cycles(2);
    nReset = 1'b1;
    fixed_wait = -1;
    InstrReady = 1'b1;
    cycles(30);
    #1;
    chk("t6_restart", 32'(model_pc != 0), 1);
    chk("t6_pc_match", 32'(pc), 32'(model_pc));
    chk("t6_romerr", 32'(RomErr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
